// File: rtl/sar_adc_ctrl_if.sv
// rtl/sar_adc_ctrl_if.sv - SAR ADC controller signal bundle
//
// Purpose: groups the conversion request, comparator feedback, DAC trial code
// and result signals of the SAR ADC controller.
// Ports (signals):
//   start_i    conversion request          (to controller)
//   abort_i    synchronous abort           (to controller)
//   cmp_i      comparator, 1 = Vin >= Vdac (to controller)
//   dac_code_o trial code to the DAC       (from controller)
//   sample_o   track/hold, 1 = track       (from controller)
//   busy_o     conversion in progress      (from controller)
//   done_o     one-cycle completion pulse  (from controller)
//   result_o   last completed result       (from controller)
// Modports: slave = the controller, master = the driver of requests.

interface sar_adc_ctrl_if #(
    parameter int N = 10
);
    logic         start_i;
    logic         abort_i;
    logic         cmp_i;
    logic [N-1:0] dac_code_o;
    logic         sample_o;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] result_o;

    modport slave (
        input  start_i, abort_i, cmp_i,
        output dac_code_o, sample_o, busy_o, done_o, result_o
    );

    modport master (
        output start_i, abort_i, cmp_i,
        input  dac_code_o, sample_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller
//
// Purpose: samples the input for SAMPLE_CYCLES, then resolves N bits MSB
// first, holding each trial code SETTLE_CYCLES before reading the comparator.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    sar_adc_ctrl_if.slave: start_i/abort_i/cmp_i in,
//          dac_code_o/sample_o/busy_o/done_o/result_o out (all registered)

module sar_adc_ctrl #(
    parameter int N             = 10,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    sar_adc_ctrl_if.slave  bus
);
    localparam int MAXC = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] SAMP_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] SETL_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [BW-1:0] IDX_MSB   = BW'(N - 1);
    localparam logic [N-1:0]  CODE_MSB  = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [BW-1:0]  r_idx;
    logic [N-1:0]   r_code;
    logic           r_sample;
    logic           r_busy;
    logic           r_done;
    logic [N-1:0]   r_result;

    logic [N-1:0]   w_next_code;

    // Code after the current decision: the bit under test keeps the comparator
    // verdict and the next lower bit becomes the new trial bit.
    always_comb begin
        w_next_code          = r_code;
        w_next_code[r_idx]   = bus.cmp_i;
        if (r_idx != '0) begin
            w_next_code[r_idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_code   <= '0;
            r_sample <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i && !bus.abort_i) begin
                        r_state  <= SAMPLE;
                        r_cnt    <= '0;
                        r_sample <= 1'b1;
                        r_busy   <= 1'b1;
                        r_code   <= '0;
                    end
                end

                SAMPLE: begin
                    if (bus.abort_i) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        r_sample <= 1'b0;
                        r_busy   <= 1'b0;
                        r_code   <= '0;
                    end else if (r_cnt == SAMP_LAST) begin
                        r_state  <= CONVERT;
                        r_cnt    <= '0;
                        r_sample <= 1'b0;
                        r_idx    <= IDX_MSB;
                        r_code   <= CODE_MSB;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                CONVERT: begin
                    if (bus.abort_i) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b0;
                        r_code  <= '0;
                    end else if (r_cnt == SETL_LAST) begin
                        r_cnt  <= '0;
                        r_code <= w_next_code;
                        if (r_idx == '0) begin
                            // LSB decided: the code is final and stays on the DAC.
                            r_state  <= IDLE;
                            r_result <= w_next_code;
                            r_done   <= 1'b1;
                            r_busy   <= 1'b0;
                        end else begin
                            r_idx <= r_idx - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    r_sample <= 1'b0;
                    r_busy   <= 1'b0;
                    r_code   <= '0;
                end
            endcase
        end
    end

    assign bus.dac_code_o = r_code;
    assign bus.sample_o   = r_sample;
    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.result_o   = r_result;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - scoreboard bench for sar_adc_ctrl

module tb_sar_adc_ctrl;
    localparam int LAT = 22;

    logic clk;
    logic rst_n;
    int   vin;
    int   cyc;
    int   n_vec;
    int   n_err;

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    sar_adc_ctrl_if #(.N(10)) bus ();

    sar_adc_ctrl #(.N(10), .SAMPLE_CYCLES(2), .SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Ideal comparator
    assign bus.cmp_i = (vin >= int'(bus.dac_code_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done_o pulse pops one expected result and its edge count.
    always @(negedge clk) begin
        if (rst_n && bus.done_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: result %0d with no pending conversion", bus.result_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", int'(bus.result_o), e.res);
                check("latency_edge", cyc, e.cyc);
            end
        end
    end

    task automatic start_conv(input int v);
        vin = v;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        exp_q.push_back('{res: v, cyc: cyc + LAT});
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.done_o && k < 40);
        if (!bus.done_o) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: no done_o within %0d cycles", name, k);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_dac"},    int'(bus.dac_code_o), 0);
        check({name, "_sample"}, int'(bus.sample_o),   0);
        check({name, "_busy"},   int'(bus.busy_o),     0);
        check({name, "_done"},   int'(bus.done_o),     0);
        check({name, "_result"}, int'(bus.result_o),   0);
    endtask

    int seq5 [10] = '{512, 256, 128, 64, 32, 16, 8, 4, 6, 5};
    int bvals[4]  = '{0, 1023, 512, 511};

    initial begin
        cyc = 0; n_vec = 0; n_err = 0; vin = 0;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // vin=5: trial sequence, latency and result
        start_conv(5);
        check("accept_sample", int'(bus.sample_o), 1);
        check("accept_busy",   int'(bus.busy_o),   1);
        for (int i = 0; i < 10; i++) begin
            repeat (2) @(posedge clk);
            #1;
            check("trial_code", int'(bus.dac_code_o), seq5[i]);
            if (i == 0) check("sample_low", int'(bus.sample_o), 0);
        end
        wait_done("vin5");
        check("busy_at_done", int'(bus.busy_o), 0);
        check("dac_final", int'(bus.dac_code_o), 5);
        @(negedge clk);
        @(negedge clk);
        check("dac_hold", int'(bus.dac_code_o), 5);

        // Boundary codes
        for (int i = 0; i < 4; i++) begin
            start_conv(bvals[i]);
            wait_done("boundary");
            check("boundary_dac", int'(bus.dac_code_o), bvals[i]);
            @(negedge clk);
        end

        // Back-to-back with ignored starts while busy
        start_conv(200);
        repeat (5) @(posedge clk);
        #1 bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (7) @(posedge clk);
        #1 bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        wait_done("b2b_first");
        start_conv(150);
        wait_done("b2b_second");
        @(negedge clk);

        // Abort during bit 6 with previous result 50
        start_conv(50);
        wait_done("pre_abort");
        @(negedge clk);
        start_conv(777);
        repeat (8) @(posedge clk);
        #1;
        check("bit6_trial", int'(bus.dac_code_o), 832);
        bus.abort_i = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        bus.abort_i = 1'b0;
        check("abort_busy",   int'(bus.busy_o),     0);
        check("abort_dac",    int'(bus.dac_code_o), 0);
        check("abort_sample", int'(bus.sample_o),   0);
        check("abort_result", int'(bus.result_o),   50);
        repeat (30) @(negedge clk);
        check("abort_result_hold", int'(bus.result_o), 50);

        // abort_i beats start_i in IDLE
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        check("abort_prio_busy", int'(bus.busy_o), 0);
        start_conv(300);
        wait_done("after_abort");
        @(negedge clk);

        // Asynchronous reset mid-SAMPLE
        start_conv(700);
        @(posedge clk);
        #3;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_zero("rst_sample");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-CONVERT
        start_conv(700);
        repeat (10) @(posedge clk);
        #2;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check_zero("rst_convert");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_no_done_result", int'(bus.result_o), 0);

        start_conv(1023);
        wait_done("after_reset");
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
